// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream, imem write port and core-control bundle of the loader
interface imem_loader_if #(parameter int INST_W = 16, parameter int DATA_W = 16);
  logic [7:0] rx_data;
  logic rx_valid, rx_ready, reload;
  logic imem_we;
  logic [DATA_W-1:0] imem_waddr;
  logic [INST_W-1:0] imem_wdata;
  logic cpu_n_rst, busy, done, err;
  modport master (
    output rx_data, rx_valid, reload,
    input  rx_ready, imem_we, imem_waddr, imem_wdata, cpu_n_rst, busy, done, err
  );
  modport slave (
    input  rx_data, rx_valid, reload,
    output rx_ready, imem_we, imem_waddr, imem_wdata, cpu_n_rst, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot loader assembling a framed, XOR-checksummed byte stream into imem words
module imem_loader #(
  parameter int INST_W = 16,
  parameter int DATA_W = 16,
  parameter int IMEM_DEPTH = 1024,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic clock,
  input logic n_rst,
  imem_loader_if.slave bus
);
  localparam int BPI = INST_W / 8;
  localparam int BW = BPI > 1 ? $clog2(BPI) : 1;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, SUM, RUN, ERROR} state_t;
  state_t state_q, state_d;
  logic [15:0] len_q, len_d, cnt_q, cnt_d, len_w;
  logic [BW-1:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic [INST_W-1:0] word_q, word_d, wdata_q, wdata_d;
  logic [DATA_W-1:0] waddr_q, waddr_d;
  logic we_q, we_d, rdy_q, busy_q, run_q, err_q, acc;
  assign acc = bus.rx_valid & rdy_q;
  assign len_w = {len_q[15:8], bus.rx_data};
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    sum_d = sum_q;
    word_d = word_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    we_d = 1'b0;
    case (state_q)
      IDLE, ERROR: if (acc && bus.rx_data == SYNC_BYTE) begin
        state_d = LEN_HI;
        sum_d = '0;
      end
      LEN_HI: if (acc) begin
        state_d = LEN_LO;
        len_d = {bus.rx_data, 8'h00};
        sum_d = sum_q ^ bus.rx_data;
      end
      LEN_LO: if (acc) begin
        len_d = len_w;
        cnt_d = '0;
        idx_d = '0;
        sum_d = sum_q ^ bus.rx_data;
        state_d = (len_w == 16'd0 || len_w > 16'(IMEM_DEPTH)) ? ERROR : DATA;
      end
      DATA: if (acc) begin
        sum_d = sum_q ^ bus.rx_data;
        word_d = INST_W'({word_q, bus.rx_data});
        idx_d = idx_q + 1'b1;
        if (idx_q == BW'(BPI - 1)) begin
          idx_d = '0;
          we_d = 1'b1;
          wdata_d = word_d;
          waddr_d = DATA_W'(cnt_q);
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) state_d = SUM;
        end
      end
      SUM: if (acc) state_d = (bus.rx_data == sum_q) ? RUN : ERROR;
      RUN: if (bus.reload) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // status outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clock)
    if (!n_rst) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
      word_q <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      we_q <= 1'b0;
      rdy_q <= 1'b0;
      busy_q <= 1'b0;
      run_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      word_q <= word_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      we_q <= we_d;
      rdy_q <= state_d != RUN;
      busy_q <= state_d inside {LEN_HI, LEN_LO, DATA, SUM};
      run_q <= state_d == RUN;
      err_q <= state_d == ERROR;
    end
  assign bus.rx_ready = rdy_q;
  assign bus.imem_we = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_n_rst = run_q;
  assign bus.done = run_q;
  assign bus.busy = busy_q;
  assign bus.err = err_q;
endmodule
